cell_write_queue: RTL

//  Buffers cell-write requests (row, col, digit) from the handwriting/mouse front end and

---
 rtl/cell_write_queue_pkg.sv | 28 ++
 rtl/cell_write_queue_fifo.sv | 55 +++++
 rtl/cell_write_queue.sv | 136 +++++++++++++
 3 files changed

// File: rtl/cell_write_queue_pkg.sv
// Shared definitions for the cell-write queue: board geometry, FSM encoding,
// request record and the row/col to cell-index mapping.
package cell_write_queue_pkg;

    localparam int SUDOKU_N = 9;
    localparam int CELLS    = SUDOKU_N * SUDOKU_N;
    localparam int IDX_W    = 7;
    localparam int REQ_W    = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_ISSUE = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0] row;
        logic [3:0] col;
        logic [3:0] data;
    } cell_req_t;

    // Flat board index row*9+col; only meaningful when row and col are 0..8.
    function automatic logic [IDX_W-1:0] idx(input logic [3:0] row, input logic [3:0] col);
        return IDX_W'(row) * IDX_W'(SUDOKU_N) + IDX_W'(col);
    endfunction

endpackage

// File: rtl/cell_write_queue_fifo.sv
// Small synchronous FIFO holding pending cell-write requests.
// A push while full succeeds only when a pop happens in the same cycle.
module cwq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage array; no reset needed since count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Wrapping pointers plus an occupancy count that separates full from empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/cell_write_queue.sv
// Queues cell-write requests from the drawing front end and hands them to the
// solver one at a time as single-cycle write strobes, dropping illegal ones.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | wait for a queued request; pop it into the holding register
//   ST_CHECK | range-check the held request and test its editable bit
//   ST_ISSUE | drive wr_pulse for one cycle with the held request
//   ST_GAP   | enforce WR_GAP idle cycles before the next request
module cell_write_queue
    import cell_write_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int WR_GAP = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             game_active,
    input  logic             req_valid,
    input  logic [3:0]       req_row,
    input  logic [3:0]       req_col,
    input  logic [3:0]       req_data,
    input  logic [CELLS-1:0] editable,
    output logic             wr_pulse,
    output logic [3:0]       wr_row,
    output logic [3:0]       wr_col,
    output logic [3:0]       wr_data,
    output logic             full,
    output logic             overflow,
    output logic [CNT_W-1:0] acc_cnt,
    output logic [CNT_W-1:0] rej_cnt
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int GW = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t          state, state_nxt;
    cell_req_t       head, hold_q, last_q;
    logic [GW-1:0]   gap_cnt;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full, fifo_empty;
    logic            ga_q, ga_rise;
    logic            push, pop, drop, reject, in_range, cell_ok;

    assign full   = (fifo_count == CW'(DEPTH));
    assign ga_rise = game_active && !ga_q;
    assign push   = req_valid && game_active && (!fifo_full || pop);
    assign drop   = req_valid && game_active && fifo_full && !pop;

    assign in_range = (hold_q.row <= 4'd8) && (hold_q.col <= 4'd8) && (hold_q.data <= 4'd9);
    assign cell_ok  = in_range && editable[idx(hold_q.row, hold_q.col)];

    // Strobe is gated by game_active so a write caught by deactivation never fires.
    assign wr_pulse = (state == ST_ISSUE) && game_active;
    assign wr_row   = wr_pulse ? hold_q.row  : last_q.row;
    assign wr_col   = wr_pulse ? hold_q.col  : last_q.col;
    assign wr_data  = wr_pulse ? hold_q.data : last_q.data;

    cwq_fifo #(.DEPTH(DEPTH), .W(REQ_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (!game_active),
        .push  (push),
        .pop   (pop),
        .wdata ({req_row, req_col, req_data}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Next-state decode; deactivation overrides everything and returns to idle.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        reject    = 1'b0;
        case (state)
            ST_IDLE:  if (!fifo_empty) begin
                          pop       = 1'b1;
                          state_nxt = ST_CHECK;
                      end
            ST_CHECK: if (cell_ok) state_nxt = ST_ISSUE;
                      else begin
                          reject    = 1'b1;
                          state_nxt = ST_IDLE;
                      end
            ST_ISSUE: state_nxt = (WR_GAP == 0) ? ST_IDLE : ST_GAP;
            ST_GAP:   if (gap_cnt == '0) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        if (!game_active) begin
            state_nxt = ST_IDLE;
            pop       = 1'b0;
            reject    = 1'b0;
        end
    end

    // Holding/last-write registers, gap timer and status counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ga_q     <= 1'b0;
            hold_q   <= '0;
            last_q   <= '0;
            gap_cnt  <= '0;
            acc_cnt  <= '0;
            rej_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            ga_q <= game_active;
            if (pop)      hold_q <= head;
            if (wr_pulse) last_q <= hold_q;
            if (state == ST_ISSUE)
                gap_cnt <= GW'((WR_GAP > 0) ? WR_GAP - 1 : 0);
            else if (state == ST_GAP && gap_cnt != '0)
                gap_cnt <= gap_cnt - 1'b1;
            if (ga_rise) begin
                acc_cnt  <= '0;
                rej_cnt  <= '0;
                overflow <= 1'b0;
            end else begin
                if (wr_pulse && acc_cnt != CNT_MAX) acc_cnt <= acc_cnt + 1'b1;
                if (reject && rej_cnt != CNT_MAX)   rej_cnt <= rej_cnt + 1'b1;
                if (drop)                           overflow <= 1'b1;
            end
        end
    end

endmodule
